// File: rtl/arith_stg_pkg.sv
// Shared definitions for the STG-style arithmetic units (shift-add multiplier,
// shift-subtract divider). Both controllers use the same state encoding and
// the same control bundle that drives their datapaths.
//
// Contents:
//   L_word_default  default operand width
//   L_state         width of the controller state register
//   state_t         S_idle=0, S_run=1, S_done=2
//   ctrl_t          {load, step, done} controller -> datapath strobes
package arith_stg_pkg;

  localparam int L_word_default = 4;
  localparam int L_state        = 3;

  typedef enum logic [L_state-1:0] {
    S_idle = 3'd0,
    S_run  = 3'd1,
    S_done = 3'd2
  } state_t;

  // load: capture operands; step: perform one iteration;
  // done: result is known at load time, so finish immediately.
  typedef struct packed {
    logic load;
    logic step;
    logic done;
  } ctrl_t;

endpackage

// File: rtl/divider_stg_datapath.sv
// Datapath of the restoring shift-subtract divider. Holds the partial
// remainder, the shifting dividend, the divisor, the quotient and the bit
// counter, plus the trial subtractor that decides each quotient bit.
//
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   ctrl            load/step/done strobes from the controller
//   word1, word2    dividend and divisor, captured on ctrl.load
//   quotient        quotient register
//   remainder       partial remainder (final remainder once done)
//   cnt_zero        high while the current step is the last one
module divider_stg_datapath
  import arith_stg_pkg::*;
#(
  parameter int L_word = L_word_default
) (
  input  logic              clock,
  input  logic              reset,
  input  ctrl_t             ctrl,
  input  logic [L_word-1:0] word1,
  input  logic [L_word-1:0] word2,
  output logic [L_word-1:0] quotient,
  output logic [L_word-1:0] remainder,
  output logic              cnt_zero
);

  localparam int L_cnt = (L_word > 1) ? $clog2(L_word) : 1;

  // The partial remainder is always below the divisor, so its extra top bit
  // would always be zero; only the low L_word bits are stored.
  logic [L_word-1:0] rem_acc;
  logic [L_word-1:0] dvd_sh;
  logic [L_word-1:0] dvs;
  logic [L_cnt-1:0]  cnt;
  logic [L_word:0]   shifted;
  logic [L_word:0]   trial;

  // A set top bit of the trial difference is the borrow: the divisor did not fit.
  assign shifted = {rem_acc, dvd_sh[L_word-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_acc  <= '0;
      dvd_sh   <= '0;
      dvs      <= '0;
      quotient <= '0;
      cnt      <= '0;
    end else if (ctrl.load) begin
      dvd_sh <= word1;
      dvs    <= word2;
      if (ctrl.done) begin
        // Zero divisor short-cut: same result the iteration would produce.
        rem_acc  <= word1;
        quotient <= '1;
        cnt      <= '0;
      end else begin
        rem_acc <= '0;
        cnt     <= L_cnt'(L_word - 1);
      end
    end else if (ctrl.step) begin
      if (!trial[L_word]) begin
        rem_acc  <= trial[L_word-1:0];
        quotient <= {quotient[L_word-2:0], 1'b1};
      end else begin
        rem_acc  <= shifted[L_word-1:0];
        quotient <= {quotient[L_word-2:0], 1'b0};
      end
      dvd_sh <= dvd_sh << 1;
      if (cnt != '0) begin
        cnt <= cnt - L_cnt'(1);
      end
    end
  end

  assign remainder = rem_acc;
  assign cnt_zero  = (cnt == '0);

endmodule

// File: rtl/divider_stg.sv
// Unsigned sequential divider, one quotient bit per clock (restoring
// shift-subtract). Start/Ready handshake matches the shift-add multiplier.
// The controller FSM and Ready decode live here; arithmetic is in
// divider_stg_datapath.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   word1, word2         dividend, divisor (sampled on the load edge)
//   Start                request, honoured only while Ready=1
//   quotient, remainder  result, valid in S_done
//   Ready                idle (and not in reset) or done
//   Div_zero             only with DIVIDER_DIV_ZERO_EN: last load had word2==0
//
// Build option: define DIVIDER_DIV_ZERO_EN to finish zero-divisor requests
// in one edge and flag them on Div_zero.
module divider_stg
  import arith_stg_pkg::*;
#(
  parameter int L_word = L_word_default
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [L_word-1:0] word1,
  input  logic [L_word-1:0] word2,
  input  logic              Start,
  output logic [L_word-1:0] quotient,
  output logic [L_word-1:0] remainder,
  output logic              Ready
`ifdef DIVIDER_DIV_ZERO_EN
  ,
  output logic              Div_zero
`endif
);

  state_t state, next_state;
  ctrl_t  ctrl;
  logic   cnt_zero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_idle;
    end else begin
      state <= next_state;
    end
  end

  // Start is only looked at in S_idle/S_done, so a request during S_run
  // is simply ignored.
  always_comb begin
    next_state = state;
    ctrl       = '0;
    case (state)
      S_idle, S_done: begin
        if (Start) begin
          ctrl.load  = 1'b1;
          next_state = S_run;
`ifdef DIVIDER_DIV_ZERO_EN
          if (word2 == '0) begin
            ctrl.done  = 1'b1;
            next_state = S_done;
          end
`endif
        end
      end
      S_run: begin
        ctrl.step = 1'b1;
        if (cnt_zero) begin
          next_state = S_done;
        end
      end
      default: next_state = S_idle;
    endcase
  end

  assign Ready = ((state == S_idle) && !reset) || (state == S_done);

`ifdef DIVIDER_DIV_ZERO_EN
  // Flag follows every load: set for a zero divisor, cleared otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Div_zero <= 1'b0;
    end else if (ctrl.load) begin
      Div_zero <= ctrl.done;
    end
  end
`endif

  divider_stg_datapath #(
    .L_word(L_word)
  ) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .ctrl     (ctrl),
    .word1    (word1),
    .word2    (word2),
    .quotient (quotient),
    .remainder(remainder),
    .cnt_zero (cnt_zero)
  );

endmodule
